minimax_bus_responder: RTL and testbench

- Synthesizable memory-side responder for the minimax core's split instruction/data bus.
- Arbitrates the core's instruction-fetch and data requests onto one single-port synchronous SRAM port, with data requests taking priority.
- Selects the fetched halfword and holds the instruction register.
- Decodes a small MMIO window holding the exit/halt register, a cycle counter and a GPIO output register. This replaces the testbench-only glue so the same core runs on silicon.

---
 rtl/minimax_bus_pkg.sv | 19 +
 rtl/minimax_bus_responder_if.sv | 25 ++
 rtl/minimax_mmio_regs.sv | 90 +++++++++
 rtl/minimax_bus_responder.sv | 131 +++++++++++++
 tb/tb_minimax_bus_responder.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/minimax_bus_pkg.sv
// Shared definitions for the minimax memory-side bus responder.
package minimax_bus_pkg;

   // Byte offsets of the registers inside the 16-byte MMIO window.
   localparam logic [3:0] MMIO_GPIO   = 4'h4;
   localparam logic [3:0] MMIO_CYCLES = 4'h8;
   localparam logic [3:0] MMIO_EXIT   = 4'hC;

   localparam logic [31:0] MMIO_BASE_DEFAULT = 32'hFFFF_FFF0;

   // Where the data response of the previous cycle comes from.
   typedef enum logic [1:0] {
      SRC_NONE = 2'd0,
      SRC_RAM  = 2'd1,
      SRC_MMIO = 2'd2,
      SRC_ERR  = 2'd3
   } src_e;

endpackage

// File: rtl/minimax_bus_responder_if.sv
// Core-side split instruction/data bus of the minimax core.
interface minimax_bus_responder_if #(
   parameter int PC_BITS = 13
);
   logic [PC_BITS-1:0] inst_addr;
   logic               inst_regce;
   logic [15:0]        inst;
   logic [31:0]        addr;
   logic [31:0]        wdata;
   logic [3:0]         wmask;
   logic               rreq;
   logic [31:0]        rdata;

   // The core drives requests and consumes responses.
   modport master (
      output inst_addr, inst_regce, addr, wdata, wmask, rreq,
      input  inst, rdata
   );

   // The responder consumes requests and drives responses.
   modport slave (
      input  inst_addr, inst_regce, addr, wdata, wmask, rreq,
      output inst, rdata
   );
endinterface

// File: rtl/minimax_mmio_regs.sv
// MMIO register block: GPIO output, free-running cycle counter, exit/halt.
module minimax_mmio_regs
   import minimax_bus_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        wr_en_i,     // data write hitting the MMIO window
   input  logic        rd_en_i,     // data read hitting the MMIO window
   input  logic [3:0]  offset_i,    // word-aligned byte offset in the window
   input  logic [31:0] wdata_i,
   input  logic [3:0]  wmask_i,
   output logic [31:0] rdata_o,     // read value, registered for the next cycle
   output logic [31:0] gpio_o,
   output logic [31:0] exit_code_o,
   output logic        halt_o
);
   logic [7:0]  gpio_q [4];
   logic [31:0] cycles_q;
   logic [31:0] exit_q;
   logic        halt_q;
   logic [31:0] rdata_q;
   logic [31:0] rdata_d;
   logic        gpio_we;
   logic        exit_we;

   assign gpio_we = wr_en_i && (offset_i == MMIO_GPIO);
   // Only a full-word write latches the exit code, and only the first one.
   assign exit_we = wr_en_i && (offset_i == MMIO_EXIT) && (wmask_i == 4'hF) && !halt_q;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_gpio_lane
         // Each GPIO byte lane is written independently under its mask bit.
         always_ff @(posedge clk) begin
            if (reset) begin
               gpio_q[gi] <= '0;
            end else if (gpio_we && wmask_i[gi]) begin
               gpio_q[gi] <= wdata_i[gi*8 +: 8];
            end
         end
         assign gpio_o[gi*8 +: 8] = gpio_q[gi];
      end
   endgenerate

   // Cycle counter runs every cycle out of reset and wraps naturally.
   always_ff @(posedge clk) begin
      if (reset) begin
         cycles_q <= '0;
      end else begin
         cycles_q <= cycles_q + 32'd1;
      end
   end

   // Exit register and sticky halt flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         exit_q <= '0;
         halt_q <= 1'b0;
      end else if (exit_we) begin
         exit_q <= wdata_i;
         halt_q <= 1'b1;
      end
   end

   // Read mux; the reserved slot and writes-only paths read as zero.
   always_comb begin
      rdata_d = '0;
      case (offset_i)
         MMIO_GPIO:   rdata_d = gpio_o;
         MMIO_CYCLES: rdata_d = cycles_q;
         MMIO_EXIT:   rdata_d = exit_q;
         default:     rdata_d = '0;
      endcase
   end

   // Register the read value so it lines up with the SRAM read latency.
   always_ff @(posedge clk) begin
      if (reset) begin
         rdata_q <= '0;
      end else if (rd_en_i) begin
         rdata_q <= rdata_d;
      end else begin
         rdata_q <= '0;
      end
   end

   assign rdata_o     = rdata_q;
   assign exit_code_o = exit_q;
   assign halt_o      = halt_q;
endmodule

// File: rtl/minimax_bus_responder.sv
// Memory-side responder: arbitrates fetch/data onto one SRAM port,
// holds the instruction register and decodes the MMIO window.
module minimax_bus_responder
   import minimax_bus_pkg::*;
#(
   parameter int          PC_BITS   = 13,
   parameter int          RAM_BYTES = 8192,
   parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEFAULT,
   localparam int         MEM_AW    = $clog2(RAM_BYTES) - 2
) (
   input  logic                 clk,
   input  logic                 reset,
   minimax_bus_responder_if.slave bus,
   output logic                 mem_en,
   output logic [MEM_AW-1:0]    mem_addr,
   output logic [3:0]           mem_wmask,
   output logic [31:0]          mem_wdata,
   input  logic [31:0]          mem_rdata,
   output logic                 halt,
   output logic [31:0]          exit_code,
   output logic [31:0]          gpio_out,
   output logic                 bus_err
);
   logic [PC_BITS-1:0] inst_addr;
   logic [31:0]        inst_addr_ext;
   logic               data_req;
   logic               ram_hit;
   logic               mmio_hit;
   logic               unmapped;
   src_e               src_d, src_q;
   logic               inst_sel_q;
   logic [15:0]        inst_q;
   logic [15:0]        fetch_half;
   logic               bus_err_q;
   logic [31:0]        mmio_rdata;
   logic [31:0]        rdata_d;
   logic               unused_bits;

   assign inst_addr     = bus.inst_addr;
   assign inst_addr_ext = {{(32-PC_BITS){1'b0}}, inst_addr};
   assign unused_bits   = ^{inst_addr_ext[31:MEM_AW+2], inst_addr_ext[0]};

   assign data_req = bus.rreq | (|bus.wmask);
   assign ram_hit  = bus.addr < 32'(RAM_BYTES);
   assign mmio_hit = bus.addr[31:4] == MMIO_BASE[31:4];
   assign unmapped = !ram_hit && !mmio_hit;

   // Port ownership: data requests win; otherwise fetch every cycle.
   always_comb begin
      mem_en    = 1'b0;
      mem_addr  = '0;
      mem_wmask = '0;
      if (!reset) begin
         if (data_req) begin
            if (ram_hit) begin
               mem_en    = 1'b1;
               mem_addr  = bus.addr[MEM_AW+1:2];
               mem_wmask = bus.wmask;
            end
         end else begin
            mem_en   = 1'b1;
            mem_addr = inst_addr_ext[MEM_AW+1:2];
         end
      end
   end
   assign mem_wdata = bus.wdata;

   // Classify this cycle's read so the response can be steered next cycle.
   always_comb begin
      src_d = SRC_NONE;
      if (bus.rreq) begin
         if (ram_hit)       src_d = SRC_RAM;
         else if (mmio_hit) src_d = SRC_MMIO;
         else               src_d = SRC_ERR;
      end
   end

   // Response source, halfword select and sticky bus-error flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         src_q      <= SRC_NONE;
         inst_sel_q <= 1'b0;
         bus_err_q  <= 1'b0;
      end else begin
         src_q      <= src_d;
         inst_sel_q <= inst_addr_ext[1];
         if (data_req && unmapped) begin
            bus_err_q <= 1'b1;
         end
      end
   end

   assign fetch_half = inst_sel_q ? mem_rdata[31:16] : mem_rdata[15:0];

   // Instruction register loads only when the core asks for it.
   always_ff @(posedge clk) begin
      if (reset) begin
         inst_q <= '0;
      end else if (bus.inst_regce) begin
         inst_q <= fetch_half;
      end
   end

   // Steer the data response from the source recorded last cycle.
   always_comb begin
      rdata_d = '0;
      case (src_q)
         SRC_RAM:  rdata_d = mem_rdata;
         SRC_MMIO: rdata_d = mmio_rdata;
         default:  rdata_d = '0;
      endcase
   end

   assign bus.rdata = rdata_d;
   assign bus.inst  = inst_q;
   assign bus_err   = bus_err_q;

   minimax_mmio_regs u_mmio (
      .clk         (clk),
      .reset       (reset),
      .wr_en_i     ((|bus.wmask) && mmio_hit),
      .rd_en_i     (bus.rreq && mmio_hit),
      .offset_i    ({bus.addr[3:2], 2'b00}),
      .wdata_i     (bus.wdata),
      .wmask_i     (bus.wmask),
      .rdata_o     (mmio_rdata),
      .gpio_o      (gpio_out),
      .exit_code_o (exit_code),
      .halt_o      (halt)
   );
endmodule

// File: tb/tb_minimax_bus_responder.sv
// Directed, table-driven bench for minimax_bus_responder with a small SRAM model.
module tb_minimax_bus_responder;
   logic        clk;
   logic        reset;
   logic        mem_en;
   logic [10:0] mem_addr;
   logic [3:0]  mem_wmask;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        halt;
   logic [31:0] exit_code;
   logic [31:0] gpio_out;
   logic        bus_err;

   logic        bd_we;
   logic [10:0] bd_addr;
   logic [31:0] bd_data;
   logic [31:0] mem [0:2047];

   int checks = 0;
   int errors = 0;

   minimax_bus_responder_if #(.PC_BITS(13)) bus ();

   minimax_bus_responder dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .mem_en    (mem_en),
      .mem_addr  (mem_addr),
      .mem_wmask (mem_wmask),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .halt      (halt),
      .exit_code (exit_code),
      .gpio_out  (gpio_out),
      .bus_err   (bus_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Read-first synchronous SRAM with byte writes and a backdoor loader.
   always @(posedge clk) begin
      if (bd_we) begin
         mem[bd_addr] <= bd_data;
      end else if (mem_en) begin
         mem_rdata <= mem[mem_addr];
         for (int b = 0; b < 4; b++) begin
            if (mem_wmask[b]) mem[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
         end
      end
   end

   typedef struct {
      logic        rq;
      logic [3:0]  wm;
      logic [31:0] a;
      logic [31:0] wd;
      logic [12:0] ia;
      logic        ce;
      logic        e_en;
      logic        chk_ma;
      logic [10:0] e_ma;
      logic [3:0]  e_wm;
      logic [31:0] e_rd;
      logic [15:0] e_inst;
      logic        e_halt;
      logic [31:0] e_exit;
      logic [31:0] e_gpio;
      logic        e_err;
   } vec_t;

   vec_t tbl [25];

   function automatic vec_t v(
      input logic rq, input logic [3:0] wm, input logic [31:0] a, input logic [31:0] wd,
      input logic [12:0] ia, input logic ce, input logic en, input logic cma,
      input logic [10:0] ma, input logic [3:0] ewm, input logic [31:0] rd,
      input logic [15:0] ins, input logic h, input logic [31:0] ex,
      input logic [31:0] gp, input logic er);
      vec_t r;
      r.rq = rq; r.wm = wm; r.a = a; r.wd = wd; r.ia = ia; r.ce = ce;
      r.e_en = en; r.chk_ma = cma; r.e_ma = ma; r.e_wm = ewm; r.e_rd = rd;
      r.e_inst = ins; r.e_halt = h; r.e_exit = ex; r.e_gpio = gp; r.e_err = er;
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic rq, input logic [3:0] wm, input logic [31:0] a,
                        input logic [31:0] wd, input logic [12:0] ia, input logic ce);
      bus.rreq       = rq;
      bus.wmask      = wm;
      bus.addr       = a;
      bus.wdata      = wd;
      bus.inst_addr  = ia;
      bus.inst_regce = ce;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   localparam logic [31:0] G = 32'h00FF00FF;

   initial begin
      // Row fields: rreq wmask addr wdata inst_addr regce | mem_en chk_ma mem_addr mem_wmask rdata inst halt exit gpio bus_err
      tbl[0]  = v(0, 4'h0, 32'h0,        32'h0,        13'h2, 0, 1, 1, 11'd0, 4'h0, 32'h0,        16'h0,    0, 32'h0, 32'h0, 0);
      tbl[1]  = v(0, 4'h0, 32'h0,        32'h0,        13'h2, 1, 1, 1, 11'd0, 4'h0, 32'h0,        16'h0,    0, 32'h0, 32'h0, 0);
      tbl[2]  = v(1, 4'h0, 32'h10,       32'h0,        13'h4, 0, 1, 1, 11'd4, 4'h0, 32'h0,        16'hBEEF, 0, 32'h0, 32'h0, 0);
      tbl[3]  = v(0, 4'h0, 32'h0,        32'h0,        13'h4, 0, 1, 1, 11'd1, 4'h0, 32'hCAFEF00D, 16'hBEEF, 0, 32'h0, 32'h0, 0);
      tbl[4]  = v(0, 4'h2, 32'h20,       32'h0000AB00, 13'h4, 1, 1, 1, 11'd8, 4'h2, 32'h0,        16'hBEEF, 0, 32'h0, 32'h0, 0);
      tbl[5]  = v(1, 4'h0, 32'h20,       32'h0,        13'h4, 0, 1, 1, 11'd8, 4'h0, 32'h0,        16'h2222, 0, 32'h0, 32'h0, 0);
      tbl[6]  = v(0, 4'h0, 32'h0,        32'h0,        13'h6, 0, 1, 1, 11'd1, 4'h0, 32'h0102AB04, 16'h2222, 0, 32'h0, 32'h0, 0);
      tbl[7]  = v(0, 4'h5, 32'hFFFFFFF4, 32'hFFFFFFFF, 13'h6, 0, 0, 0, 11'd0, 4'h0, 32'h0,        16'h2222, 0, 32'h0, 32'h0, 0);
      tbl[8]  = v(1, 4'h0, 32'hFFFFFFF4, 32'h0,        13'h6, 0, 0, 0, 11'd0, 4'h0, 32'h0,        16'h2222, 0, 32'h0, G,     0);
      tbl[9]  = v(1, 4'h0, 32'hFFFFFFF8, 32'h0,        13'h6, 0, 0, 0, 11'd0, 4'h0, G,            16'h2222, 0, 32'h0, G,     0);
      tbl[10] = v(0, 4'h0, 32'h0,        32'h0,        13'h6, 0, 1, 1, 11'd1, 4'h0, 32'd9,        16'h2222, 0, 32'h0, G,     0);
      tbl[11] = v(0, 4'h0, 32'h0,        32'h0,        13'h6, 0, 1, 1, 11'd1, 4'h0, 32'h0,        16'h2222, 0, 32'h0, G,     0);
      tbl[12] = v(1, 4'h0, 32'hFFFFFFF8, 32'h0,        13'h6, 0, 0, 0, 11'd0, 4'h0, 32'h0,        16'h2222, 0, 32'h0, G,     0);
      tbl[13] = v(0, 4'h0, 32'h0,        32'h0,        13'h6, 0, 1, 1, 11'd1, 4'h0, 32'd12,       16'h2222, 0, 32'h0, G,     0);
      tbl[14] = v(0, 4'hF, 32'hFFFFFFFC, 32'h5,        13'h6, 0, 0, 0, 11'd0, 4'h0, 32'h0,        16'h2222, 0, 32'h0, G,     0);
      tbl[15] = v(0, 4'hF, 32'hFFFFFFFC, 32'h7,        13'h6, 0, 0, 0, 11'd0, 4'h0, 32'h0,        16'h2222, 1, 32'h5, G,     0);
      tbl[16] = v(1, 4'h0, 32'hFFFFFFFC, 32'h0,        13'h6, 0, 0, 0, 11'd0, 4'h0, 32'h0,        16'h2222, 1, 32'h5, G,     0);
      tbl[17] = v(0, 4'h0, 32'h0,        32'h0,        13'h6, 0, 1, 1, 11'd1, 4'h0, 32'h5,        16'h2222, 1, 32'h5, G,     0);
      tbl[18] = v(1, 4'h0, 32'h00004000, 32'h0,        13'h6, 0, 0, 0, 11'd0, 4'h0, 32'h0,        16'h2222, 1, 32'h5, G,     0);
      tbl[19] = v(1, 4'h0, 32'hFFFFFFF0, 32'h0,        13'h6, 0, 0, 0, 11'd0, 4'h0, 32'h0,        16'h2222, 1, 32'h5, G,     1);
      tbl[20] = v(0, 4'h0, 32'h0,        32'h0,        13'h6, 0, 1, 1, 11'd1, 4'h0, 32'h0,        16'h2222, 1, 32'h5, G,     1);
      tbl[21] = v(1, 4'hF, 32'h10,       32'h12345678, 13'h6, 0, 1, 1, 11'd4, 4'hF, 32'h0,        16'h2222, 1, 32'h5, G,     1);
      tbl[22] = v(1, 4'h0, 32'h10,       32'h0,        13'h6, 0, 1, 1, 11'd4, 4'h0, 32'hCAFEF00D, 16'h2222, 1, 32'h5, G,     1);
      tbl[23] = v(0, 4'h0, 32'h0,        32'h0,        13'h6, 1, 1, 1, 11'd1, 4'h0, 32'h12345678, 16'h2222, 1, 32'h5, G,     1);
      tbl[24] = v(0, 4'h0, 32'h0,        32'h0,        13'h6, 0, 1, 1, 11'd1, 4'h0, 32'h0,        16'h1234, 1, 32'h5, G,     1);

      // Reset with backdoor SRAM preload; a request during reset must not reach the port.
      reset = 1'b1;
      bd_we = 1'b0; bd_addr = '0; bd_data = '0;
      mem_rdata = '0;
      drive(1, 4'hF, 32'h10, 32'hDEADBEEF, 13'h0, 0);
      next_cycle();
      bd_we = 1'b1; bd_addr = 11'd0; bd_data = 32'hBEEF1234; next_cycle();
      bd_addr = 11'd1; bd_data = 32'h11112222; next_cycle();
      bd_addr = 11'd4; bd_data = 32'hCAFEF00D; next_cycle();
      bd_addr = 11'd8; bd_data = 32'h01020304; next_cycle();
      bd_we = 1'b0;
      #4;
      chk("rst_mem_en", 32'(mem_en), 32'h0);
      chk("rst_mem_wmask", 32'(mem_wmask), 32'h0);
      chk("rst_mem_addr", 32'(mem_addr), 32'h0);
      chk("rst_rdata", bus.rdata, 32'h0);
      chk("rst_inst", 32'(bus.inst), 32'h0);
      chk("rst_halt", 32'(halt), 32'h0);
      chk("rst_gpio", gpio_out, 32'h0);
      chk("rst_bus_err", 32'(bus_err), 32'h0);
      next_cycle();

      // Table: one row per cycle, outputs sampled mid-cycle.
      reset = 1'b0;
      for (int i = 0; i < 25; i++) begin
         drive(tbl[i].rq, tbl[i].wm, tbl[i].a, tbl[i].wd, tbl[i].ia, tbl[i].ce);
         #4;
         chk($sformatf("row%0d_mem_en", i), 32'(mem_en), 32'(tbl[i].e_en));
         if (tbl[i].chk_ma) chk($sformatf("row%0d_mem_addr", i), 32'(mem_addr), 32'(tbl[i].e_ma));
         chk($sformatf("row%0d_mem_wmask", i), 32'(mem_wmask), 32'(tbl[i].e_wm));
         chk($sformatf("row%0d_rdata", i), bus.rdata, tbl[i].e_rd);
         chk($sformatf("row%0d_inst", i), 32'(bus.inst), 32'(tbl[i].e_inst));
         chk($sformatf("row%0d_halt", i), 32'(halt), 32'(tbl[i].e_halt));
         chk($sformatf("row%0d_exit", i), exit_code, tbl[i].e_exit);
         chk($sformatf("row%0d_gpio", i), gpio_out, tbl[i].e_gpio);
         chk($sformatf("row%0d_bus_err", i), 32'(bus_err), 32'(tbl[i].e_err));
         $display("row %0d: rreq=%0b wmask=%h addr=%h rdata=%h inst=%h halt=%0b gpio=%h err=%0b",
                  i, tbl[i].rq, tbl[i].wm, tbl[i].a, bus.rdata, bus.inst, halt, gpio_out, bus_err);
         next_cycle();
      end

      // Reset in the middle of a pending read discards the response.
      drive(1, 4'h0, 32'h10, 32'h0, 13'h0, 0);
      next_cycle();
      reset = 1'b1;
      drive(1, 4'hF, 32'h20, 32'h0, 13'h0, 1);
      #4;
      chk("midrst_mem_en", 32'(mem_en), 32'h0);
      chk("midrst_mem_wmask", 32'(mem_wmask), 32'h0);
      chk("midrst_mem_addr", 32'(mem_addr), 32'h0);
      $display("seq midrst: reset asserted with pending read");
      next_cycle();
      reset = 1'b0;
      drive(0, 4'h0, 32'h0, 32'h0, 13'h0, 0);
      #4;
      chk("postrst_rdata", bus.rdata, 32'h0);
      chk("postrst_inst", 32'(bus.inst), 32'h0);
      chk("postrst_halt", 32'(halt), 32'h0);
      chk("postrst_exit", exit_code, 32'h0);
      chk("postrst_gpio", gpio_out, 32'h0);
      chk("postrst_bus_err", 32'(bus_err), 32'h0);
      $display("seq postrst: rdata=%h inst=%h halt=%0b gpio=%h err=%0b", bus.rdata, bus.inst, halt, gpio_out, bus_err);
      next_cycle();
      // Cycle counter restarted: second cycle out of reset reads 1.
      drive(1, 4'h0, 32'hFFFFFFF8, 32'h0, 13'h0, 0);
      next_cycle();
      drive(1, 4'h0, 32'h20, 32'h0, 13'h0, 0);
      #4;
      chk("postrst_cycles", bus.rdata, 32'd1);
      $display("seq cycles after reset: rdata=%h", bus.rdata);
      next_cycle();
      drive(0, 4'h0, 32'h0, 32'h0, 13'h0, 0);
      #4;
      chk("rst_write_dropped", bus.rdata, 32'h0102AB04);
      $display("seq word8 after reset-time write: rdata=%h", bus.rdata);
      next_cycle();

      // Partial exit write is ignored; full write then halts.
      drive(0, 4'h7, 32'hFFFFFFFC, 32'h33, 13'h0, 0);
      next_cycle();
      drive(0, 4'hF, 32'hFFFFFFFC, 32'hA, 13'h0, 0);
      #4;
      chk("partial_exit_halt", 32'(halt), 32'h0);
      chk("partial_exit_code", exit_code, 32'h0);
      next_cycle();
      drive(0, 4'h0, 32'h0, 32'h0, 13'h0, 0);
      #4;
      chk("full_exit_halt", 32'(halt), 32'h1);
      chk("full_exit_code", exit_code, 32'hA);
      $display("seq exit: halt=%0b exit_code=%h", halt, exit_code);
      next_cycle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
